leaf_stream_packetizer: RTL and testbench
=========================================

LEAF_STREAM_PACKETIZER -- requirements
Module: leaf_stream_packetizer

Interface
REQ-001 Parameter PACKET_BITS, default 49: width of one BFT packet.
REQ-002 Parameter PAYLOAD_BITS, default 32: width of the user data word.
REQ-003 Parameter NUM_LEAF_BITS, default 5: width of the destination-leaf field.
REQ-004 Parameter NUM_PORT_BITS, default 4: width of the destination-port field.
REQ-005 Parameter NUM_ADDR_BITS, default 7: width of the destination BRAM address field.
REQ-006 Parameter DEST_LEAF, default 0: constant destination leaf.
REQ-007 Parameter DEST_PORT, default 0: constant destination port.
REQ-008 Parameter CREDIT_INIT, default 128: initial and maximum credit count; equals the destination buffer depth.
REQ-009 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-010 Port reset, input, 1: asynchronous, active-high reset.
REQ-011 Port ap_start, input, 1: level enable for the stage.
REQ-012 Port din_leaf_user2interface, input, PAYLOAD_BITS: user data word.
REQ-013 Port vld_user2interface, input, 1: user data valid.
REQ-014 Port ack_interface2user, output, 1: word accepted this cycle.
REQ-015 Port credit_vld, input, 1: credit return strobe.
REQ-016 Port credit_cnt, input, 8: number of credits returned; the value is ignored unless credit_vld is high.
REQ-017 Port resend, input, 1: network requests that the last output packet be held.
REQ-018 Port dout_leaf_interface2bft, output, PACKET_BITS: packet to the BFT.
REQ-019 Port pkt_count, output, 32: total packets emitted since reset.

Function
REQ-020 Packet layout: [48] valid, [47:43] DEST_LEAF, [42:39] DEST_PORT, [38:32] addr, [31:0] payload.
REQ-021 FSM states: IDLE and RUN.
REQ-022 FSM transitions: IDLE->RUN when ap_start=1; RUN->IDLE when ap_start=0; addr and credit state are preserved across these transitions.
REQ-023 ack_interface2user SHALL be combinational: (state==RUN) && (credits!=0) && !resend.
REQ-024 Accept occurs when vld_user2interface && ack_interface2user are both high in the same cycle.
REQ-025 On accept, dout_leaf_interface2bft SHALL present the formed packet with valid=1 on the next cycle (latency 1).
REQ-026 On accept, addr SHALL increment, wrapping 127->0.
REQ-027 On accept, credits SHALL decrement and pkt_count SHALL increment (32-bit, wrapping).
REQ-028 In a cycle with no accept and resend=0, dout SHALL be all zeros on the next cycle.
REQ-029 While resend=1, dout SHALL hold its current value unchanged, and no accept occurs.
REQ-030 When resend falls, normal operation resumes on the next cycle.
REQ-031 On credit_vld, credits SHALL become min(CREDIT_INIT, credits - accept + credit_cnt), computed at 9-bit width.
REQ-032 A simultaneous accept and credit return SHALL both take effect in the same cycle.
REQ-033 At credits==0, ack SHALL be 0 and vld_user2interface may stay high without loss; a credit return makes ack high on the following cycle.
REQ-034 ap_start falling in the same cycle as an accept: that accepted packet is still emitted.

Reset
REQ-035 Reset SHALL put the FSM in IDLE.
REQ-036 Reset values: dout=0, addr=0, credits=CREDIT_INIT, pkt_count=0, ack=0.
REQ-037 Reset asserted mid-operation SHALL discard any in-flight packet immediately, asynchronously.
REQ-038 After reset deasserts, the first packet carries addr=0.

Structure
REQ-039 Packet field widths, field bit offsets and the FSM state encoding SHALL reside in the shared leaf package.
REQ-040 Credit arithmetic and saturation SHALL be one sub-module, credit_counter (ports: clk, reset, dec, inc_vld, inc_cnt, credits).
REQ-041 All remaining logic SHALL be flat in leaf_stream_packetizer.

Verification
REQ-042 Reset, then ap_start=1, then 3 words 0xA,0xB,0xC back-to-back -> packets on cycles 2-4 with addr 0,1,2, valid=1, leaf/port fields = parameters; pkt_count=3.
REQ-043 128 words with no credit return -> ack low after word 128, the 129th word is held; then credit_vld with cnt=1 -> word 129 emitted with addr=0 (wrap).
REQ-044 resend high for 4 cycles after packet addr=5 -> dout stays the addr=5 packet, ack=0; the next packet after resend falls is addr=6.
REQ-045 Accept plus credit_vld with cnt=1 in the same cycle, starting from credits=10 -> credits=10; credit_vld with cnt=200 -> credits saturate at 128.
REQ-046 Reset asserted mid-stream after 7 packets -> dout=0 at once; pkt_count=0; the next packet after restart has addr=0 and credits=127.

Source files
------------

// File: rtl/leaf_stream_packetizer_pkg.sv
// Shared definitions for the leaf stream packetizer: BFT packet field
// geometry, credit arithmetic width and the FSM state encoding.
package leaf_stream_packetizer_pkg;

  localparam int PACKET_W    = 49;
  localparam int PAYLOAD_W   = 32;
  localparam int LEAF_W      = 5;
  localparam int PORT_W      = 4;
  localparam int ADDR_W      = 7;
  localparam int CREDIT_W    = 9;
  localparam int CREDIT_CNTW = 8;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_LSB    = 43;
  localparam int PORT_LSB    = 39;
  localparam int ADDR_LSB    = 32;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/leaf_stream_packetizer_credit_counter.sv
// Tracks the credits available at the destination buffer: one credit is
// consumed per accepted word, returned credits are added and capped.
module credit_counter
  import leaf_stream_packetizer_pkg::*;
#(
  parameter int CREDIT_INIT = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec,
  input  logic                   inc_vld,
  input  logic [CREDIT_CNTW-1:0] inc_cnt,
  output logic [CREDIT_W-1:0]    credits
);

  localparam logic [CREDIT_W-1:0] CREDIT_CAP = CREDIT_W'(CREDIT_INIT);

  logic [CREDIT_W-1:0] credits_q;
  logic [CREDIT_W-1:0] credits_d;
  logic [CREDIT_W-1:0] sum;

  // Consume and return are merged into one 9-bit sum before saturating,
  // so a simultaneous accept and return both count.
  always_comb begin
    sum       = credits_q - CREDIT_W'(dec) + CREDIT_W'(inc_cnt);
    credits_d = credits_q - CREDIT_W'(dec);
    if (inc_vld) begin
      credits_d = (sum > CREDIT_CAP) ? CREDIT_CAP : sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q <= CREDIT_CAP;
    end else begin
      credits_q <= credits_d;
    end
  end

  assign credits = credits_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Wraps user data words into BFT packets for a fixed destination leaf/port,
// with credit-based flow control and a resend hold on the output register.
module leaf_stream_packetizer
  import leaf_stream_packetizer_pkg::*;
#(
  parameter int PACKET_BITS   = PACKET_W,
  parameter int PAYLOAD_BITS  = PAYLOAD_W,
  parameter int NUM_LEAF_BITS = LEAF_W,
  parameter int NUM_PORT_BITS = PORT_W,
  parameter int NUM_ADDR_BITS = ADDR_W,
  parameter int DEST_LEAF     = 0,
  parameter int DEST_PORT     = 0,
  parameter int CREDIT_INIT   = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic                    vld_user2interface,
  output logic                    ack_interface2user,
  input  logic                    credit_vld,
  input  logic [7:0]              credit_cnt,
  input  logic                    resend,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  output logic [31:0]             pkt_count
);

  localparam logic [NUM_LEAF_BITS-1:0] LEAF_FIELD = NUM_LEAF_BITS'(DEST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] PORT_FIELD = NUM_PORT_BITS'(DEST_PORT);

  state_e                   state_q;
  state_e                   state_d;
  logic [PACKET_BITS-1:0]   dout_q;
  logic [PACKET_BITS-1:0]   dout_d;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [NUM_ADDR_BITS-1:0] addr_d;
  logic [31:0]              cnt_q;
  logic [31:0]              cnt_d;
  logic [PACKET_BITS-1:0]   packet;
  logic [CREDIT_W-1:0]      credits;
  logic                     accept;

  credit_counter #(
    .CREDIT_INIT(CREDIT_INIT)
  ) u_credit_counter (
    .clk    (clk),
    .reset  (reset),
    .dec    (accept),
    .inc_vld(credit_vld),
    .inc_cnt(credit_cnt),
    .credits(credits)
  );

  assign ack_interface2user = (state_q == RUN) && (credits != '0) && !resend;
  assign accept             = vld_user2interface && ack_interface2user;

  // Resend freezes the output register; otherwise it carries the freshly
  // formed packet on accept and idles at zero.
  always_comb begin
    packet                                   = '0;
    packet[VALID_BIT]                        = 1'b1;
    packet[LEAF_LSB +: NUM_LEAF_BITS]        = LEAF_FIELD;
    packet[PORT_LSB +: NUM_PORT_BITS]        = PORT_FIELD;
    packet[ADDR_LSB +: NUM_ADDR_BITS]        = addr_q;
    packet[PAYLOAD_LSB +: PAYLOAD_BITS]      = din_leaf_user2interface;

    state_d = ap_start ? RUN : IDLE;
    addr_d  = accept ? addr_q + NUM_ADDR_BITS'(1) : addr_q;
    cnt_d   = accept ? cnt_q + 32'd1 : cnt_q;
    if (resend) begin
      dout_d = dout_q;
    end else if (accept) begin
      dout_d = packet;
    end else begin
      dout_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign pkt_count               = cnt_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed and randomized checks of leaf_stream_packetizer against a
// cycle-level behavioural model of the packet, credit and resend rules.
module tb_leaf_stream_packetizer;

  localparam int TB_LEAF   = 19;
  localparam int TB_PORT   = 9;
  localparam int TB_CREDIT = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        apStart = 1'b0;
  logic [31:0] dinWord = '0;
  logic        vldIn = 1'b0;
  logic        ackOut;
  logic        creditVld = 1'b0;
  logic [7:0]  creditCnt = '0;
  logic        resendIn = 1'b0;
  logic [48:0] doutPkt;
  logic [31:0] pktCount;

  int          mRunning;
  int          mCredits;
  int          mAddr;
  logic [31:0] mCount;
  logic [48:0] mDout;

  int assertCount = 0;
  int failCount   = 0;

  leaf_stream_packetizer #(
    .PACKET_BITS  (49),
    .PAYLOAD_BITS (32),
    .NUM_LEAF_BITS(5),
    .NUM_PORT_BITS(4),
    .NUM_ADDR_BITS(7),
    .DEST_LEAF    (TB_LEAF),
    .DEST_PORT    (TB_PORT),
    .CREDIT_INIT  (TB_CREDIT)
  ) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .ap_start               (apStart),
    .din_leaf_user2interface(dinWord),
    .vld_user2interface     (vldIn),
    .ack_interface2user     (ackOut),
    .credit_vld             (creditVld),
    .credit_cnt             (creditCnt),
    .resend                 (resendIn),
    .dout_leaf_interface2bft(doutPkt),
    .pkt_count              (pktCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [48:0] expectedPacket(input int addr, input logic [31:0] data);
    logic [6:0] a;
    a = 7'(addr % 128);
    return {1'b1, 5'(TB_LEAF), 4'(TB_PORT), a, data};
  endfunction

  task automatic modelReset();
    mRunning = 0;
    mCredits = TB_CREDIT;
    mAddr    = 0;
    mCount   = '0;
    mDout    = '0;
  endtask

  // One clock cycle: drive inputs on the falling edge, check the
  // combinational ack, then advance the model and check registered outputs.
  task automatic applyStimulus(input logic ap, input logic vld, input logic [31:0] data,
                               input logic cv, input logic [7:0] cc, input logic rs);
    logic expAck;
    logic accept;
    int   tmp;
    @(negedge clk);
    apStart   = ap;
    vldIn     = vld;
    dinWord   = data;
    creditVld = cv;
    creditCnt = cc;
    resendIn  = rs;
    #1;
    expAck = (mRunning != 0) && (mCredits != 0) && !rs;
    checkOutput("ack", 64'(ackOut), 64'(expAck));
    accept = vld && expAck;
    @(posedge clk);
    if (!rs) mDout = accept ? expectedPacket(mAddr, data) : '0;
    if (accept) begin
      mAddr  = (mAddr + 1) % 128;
      mCount = mCount + 32'd1;
    end
    if (cv) begin
      tmp      = mCredits - int'(accept) + int'(cc);
      mCredits = (tmp > TB_CREDIT) ? TB_CREDIT : tmp;
    end else begin
      mCredits = mCredits - int'(accept);
    end
    mRunning = ap ? 1 : 0;
    #1;
    checkOutput("dout", 64'(doutPkt), 64'(mDout));
    checkOutput("pkt_count", 64'(pktCount), 64'(mCount));
    checkOutput("credits", 64'(u_dut.credits), 64'(mCredits));
  endtask

  // Reset is raised between clock edges to exercise its asynchronous path.
  task automatic applyReset();
    @(negedge clk);
    #2;
    reset     = 1'b1;
    apStart   = 1'b0;
    vldIn     = 1'b0;
    creditVld = 1'b0;
    creditCnt = '0;
    resendIn  = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_dout", 64'(doutPkt), 64'd0);
    checkOutput("reset_pkt_count", 64'(pktCount), 64'd0);
    checkOutput("reset_ack", 64'(ackOut), 64'd0);
    checkOutput("reset_credits", 64'(u_dut.credits), 64'(TB_CREDIT));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sendWords(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic        ap;
    logic        vld;
    logic        cv;
    logic        rs;
    logic [7:0]  cc;

    modelReset();
    applyReset();

    // Three back-to-back words after start.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hA, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hC, 1'b0, 8'd0, 1'b0);
    checkOutput("three_words_count", 64'(pktCount), 64'd3);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);

    // Credit exhaustion and address wrap.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    sendWords(128);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h129, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h129, 1'b1, 8'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h129, 1'b0, 8'd0, 1'b0);
    checkOutput("wrap_addr", 64'(doutPkt[38:32]), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);

    // Resend hold after the addr=5 packet.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    sendWords(6);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 8'd0, 1'b1);
    checkOutput("resend_hold_addr", 64'(doutPkt[38:32]), 64'd5);
    applyStimulus(1'b1, 1'b1, 32'h66, 1'b0, 8'd0, 1'b0);
    checkOutput("after_resend_addr", 64'(doutPkt[38:32]), 64'd6);

    // Simultaneous accept and return, then saturation.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    sendWords(118);
    applyStimulus(1'b1, 1'b1, 32'h77, 1'b1, 8'd1, 1'b0);
    checkOutput("accept_and_return", 64'(u_dut.credits), 64'd10);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 8'd200, 1'b0);
    checkOutput("saturate", 64'(u_dut.credits), 64'd128);

    // Reset in the middle of a stream.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    sendWords(7);
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h99, 1'b0, 8'd0, 1'b0);
    checkOutput("restart_addr", 64'(doutPkt[38:32]), 64'd0);
    checkOutput("restart_credits", 64'(u_dut.credits), 64'd127);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) applyReset();
      ap  = ($urandom_range(0, 19) != 0);
      vld = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 7) == 0);
      cv  = ($urandom_range(0, 5) == 0);
      cc  = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 8));
      applyStimulus(ap, vld, $urandom, cv, cc, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
